// File: rtl/cpu_dbus_wb_master.sv
// Wishbone classic master for the MiniMIPS32 memory-stage data port.
// Turns a single-cycle ce/we/sel/addr/data request into one bus cycle,
// stalls the pipeline until it terminates, and aborts on a bus timeout.
module cpu_dbus_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      rd_buf;

  logic busy_flush;
  logic term_ack;
  logic term_to;
  logic accept;

  // Termination conditions; flush outranks ack, ack outranks timeout
  always_comb begin
    accept     = cpu_ce_i && !flush_i;
    busy_flush = (state == BUSY) && flush_i;
    term_ack   = (state == BUSY) && !flush_i && wb_ack_i;
    term_to    = (state == BUSY) && !flush_i && !wb_ack_i && (cnt == CNT_LAST);
  end

  // Pipeline-facing outputs, valid in the same cycle as the bus event
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    bus_err_o  = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so the stall drops immediately while reset is held
        stallreq_o = wb_rst_i && accept;
      end
      BUSY: begin
        stallreq_o = !(busy_flush || term_ack || term_to);
        if (term_ack && !wb_we_o) begin
          cpu_data_o = wb_dat_i;
        end
        bus_err_o = term_to;
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
      end
      default: begin
        stallreq_o = 1'b0;
      end
    endcase
  end

  // Bus cycle FSM with registered Wishbone outputs
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_buf   <= 32'h0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 32'h0;
      wb_dat_o <= 32'h0;
      wb_sel_o <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cpu_we_i;
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_sel_o <= cpu_sel_i;
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (busy_flush || term_ack || term_to) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
            if (busy_flush) begin
              state <= IDLE;
            end else begin
              rd_buf <= (term_ack && !wb_we_o) ? wb_dat_i : 32'h0;
              state  <= stall_i ? WAIT_STALL : IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_STALL: begin
          if (!stall_i || flush_i) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
